onehot_enc_pipe: RTL and testbench

Multi-channel, registered one-hot-to-binary encoder with a valid/ready handshake. It is the parametrised successor to the combinational one-hot decoder.
- Adds per-channel multi-hot error detection.
- Adds a selectable priority for multi-hot inputs.
- Provides backpressure-safe buffering between an arbiter/grant stage and downstream index consumers, e.g. a crossbar select or a FIFO write pointer.

---
 rtl/onehot_pkg.sv | 19 +
 rtl/onehot_enc_ch.sv | 32 +++
 rtl/onehot_enc_pipe.sv | 108 ++++++++++
 tb/tb_onehot_enc_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types, default widths and the multi-hot detect helper for the one-hot encoder pipeline.
package onehot_pkg;

  typedef enum logic {
    PRIO_LOW  = 1'b0,
    PRIO_HIGH = 1'b1
  } prio_e;

  localparam int DEF_INPUT_WIDTH   = 8;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_ERR_CNT_WIDTH = 8;
  localparam int ONEHOT_MAX_W      = 256;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic onehot_popcnt_gt1(input logic [ONEHOT_MAX_W-1:0] v);
    return |(v & (v - ONEHOT_MAX_W'(1)));
  endfunction

endpackage

// File: rtl/onehot_enc_ch.sv
// Combinational single-channel one-hot to binary encoder with multi-hot flag.
// Multi-hot inputs resolve to the highest or lowest set index depending on PRIO.
module onehot_enc_ch
  import onehot_pkg::*;
#(
  parameter int    INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int    OUTPUT_WIDTH = $clog2(INPUT_WIDTH),
  parameter prio_e PRIO         = PRIO_HIGH
) (
  input  logic [INPUT_WIDTH-1:0]  oh_i,
  output logic [OUTPUT_WIDTH-1:0] idx_o,
  output logic                    ch_valid_o,
  output logic                    ch_err_o
);

  always_comb begin
    idx_o = '0;
    if (PRIO == PRIO_HIGH) begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (oh_i[i]) idx_o = OUTPUT_WIDTH'(i);
      end
    end else begin
      for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
        if (oh_i[i]) idx_o = OUTPUT_WIDTH'(i);
      end
    end
  end

  assign ch_valid_o = |oh_i;
  assign ch_err_o   = onehot_popcnt_gt1(ONEHOT_MAX_W'(oh_i));

endmodule

// File: rtl/onehot_enc_pipe.sv
// Multi-channel registered one-hot encoder, one output register stage, 1-cycle latency, full throughput.
// Saturating multi-hot error counter is built only with ONEHOT_ENC_ERR_CNT_EN defined.
module onehot_enc_pipe #(
  parameter int INPUT_WIDTH   = onehot_pkg::DEF_INPUT_WIDTH,
  parameter int NUM_CH        = onehot_pkg::DEF_NUM_CH,
  parameter int OUTPUT_WIDTH  = $clog2(INPUT_WIDTH),
  parameter int PRIO_HIGH     = 1,
  parameter int ERR_CNT_WIDTH = onehot_pkg::DEF_ERR_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*INPUT_WIDTH-1:0]  one_hot_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*OUTPUT_WIDTH-1:0] binary_out,
  output logic [NUM_CH-1:0]              ch_valid,
  output logic [NUM_CH-1:0]              ch_err,
  output logic [ERR_CNT_WIDTH-1:0]       err_count,
  input  logic                           err_count_clr
);
  import onehot_pkg::*;

  logic                           in_hs;
  logic                           out_hs;
  logic                           out_valid_q, out_valid_d;
  logic [NUM_CH*OUTPUT_WIDTH-1:0] bin_q, bin_d;
  logic [NUM_CH-1:0]              ch_valid_q, ch_valid_d;
  logic [NUM_CH-1:0]              ch_err_q, ch_err_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    onehot_enc_ch #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .PRIO         (prio_e'(PRIO_HIGH != 0))
    ) u_enc (
      .oh_i       (one_hot_in[c*INPUT_WIDTH +: INPUT_WIDTH]),
      .idx_o      (bin_d[c*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
      .ch_valid_o (ch_valid_d[c]),
      .ch_err_o   (ch_err_d[c])
    );
  end

  // Register slot frees up in the same cycle the downstream consumes it.
  assign in_ready = !out_valid_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (in_hs) begin
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      ch_valid_q  <= '0;
      ch_err_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (in_hs) begin
        bin_q      <= bin_d;
        ch_valid_q <= ch_valid_d;
        ch_err_q   <= ch_err_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign binary_out = bin_q;
  assign ch_valid   = ch_valid_q;
  assign ch_err     = ch_err_q;

`ifdef ONEHOT_ENC_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_count_clr) begin
      err_cnt_d = '0;
    end else if (in_hs && (|ch_err_d) && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_count_clr;
  assign unused_err_count_clr = err_count_clr;
  assign err_count            = '0;
`endif

endmodule

// File: tb/tb_onehot_enc_pipe.sv
// Scoreboard bench: two encoder instances (high/8-bit counter, low/2-bit counter) share one stimulus stream.
module tb_onehot_enc_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        err_count_clr;
  logic [31:0] one_hot_in;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [11:0] a_bin, b_bin;
  logic [3:0]  a_chv, a_che, b_chv, b_che;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  onehot_enc_pipe #(.INPUT_WIDTH(8), .NUM_CH(4), .PRIO_HIGH(1), .ERR_CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .one_hot_in(one_hot_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .binary_out(a_bin), .ch_valid(a_chv), .ch_err(a_che),
    .err_count(a_cnt), .err_count_clr(err_count_clr)
  );

  onehot_enc_pipe #(.INPUT_WIDTH(8), .NUM_CH(4), .PRIO_HIGH(0), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .one_hot_in(one_hot_in), .out_valid(b_out_valid), .out_ready(out_ready),
    .binary_out(b_bin), .ch_valid(b_chv), .ch_err(b_che),
    .err_count(b_cnt), .err_count_clr(err_count_clr)
  );

  typedef struct packed {
    logic [11:0] bin;
    logic [3:0]  chv;
    logic [3:0]  che;
    logic [7:0]  cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops_a   = 0;
  int   cyc      = 0;
  int   cnt_a    = 0;
  int   cnt_b    = 0;

  // Hand-computed vectors; bins are {ch3,ch2,ch1,ch0} 3-bit indices.
  logic [31:0] vec_oh [6];
  logic [11:0] vec_hi [6];
  logic [11:0] vec_lo [6];
  logic [3:0]  vec_chv[6];
  logic [3:0]  vec_che[6];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_oh[0] = 32'h0000_0008; vec_hi[0] = {3'd0, 3'd0, 3'd0, 3'd3}; vec_lo[0] = {3'd0, 3'd0, 3'd0, 3'd3};
    vec_chv[0] = 4'b0001; vec_che[0] = 4'b0000;
    vec_oh[1] = 32'h0000_9000; vec_hi[1] = {3'd0, 3'd0, 3'd7, 3'd0}; vec_lo[1] = {3'd0, 3'd0, 3'd4, 3'd0};
    vec_chv[1] = 4'b0010; vec_che[1] = 4'b0010;
    vec_oh[2] = 32'h00FF_8001; vec_hi[2] = {3'd0, 3'd7, 3'd7, 3'd0}; vec_lo[2] = {3'd0, 3'd0, 3'd7, 3'd0};
    vec_chv[2] = 4'b0111; vec_che[2] = 4'b0100;
    vec_oh[3] = 32'h2440_0206; vec_hi[3] = {3'd5, 3'd6, 3'd1, 3'd2}; vec_lo[3] = {3'd2, 3'd6, 3'd1, 3'd1};
    vec_chv[3] = 4'b1111; vec_che[3] = 4'b1001;
    vec_oh[4] = 32'h0000_0000; vec_hi[4] = 12'h000; vec_lo[4] = 12'h000;
    vec_chv[4] = 4'b0000; vec_che[4] = 4'b0000;
    vec_oh[5] = 32'h0210_0180; vec_hi[5] = {3'd1, 3'd4, 3'd0, 3'd7}; vec_lo[5] = {3'd1, 3'd4, 3'd0, 3'd7};
    vec_chv[5] = 4'b1111; vec_che[5] = 4'b0000;
  end

  // Monitor: compares the head entry every cycle a beat is shown, pops on output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (a_out_valid) begin
          if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
          else begin
            e = qa[0];
            chk("a_binary_out", 32'(a_bin), 32'(e.bin));
            chk("a_ch_valid", 32'(a_chv), 32'(e.chv));
            chk("a_ch_err", 32'(a_che), 32'(e.che));
            chk("a_err_count", 32'(a_cnt), 32'(e.cnt));
            if (out_ready) begin
              void'(qa.pop_front());
              pops_a++;
            end
          end
        end
        if (b_out_valid) begin
          if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
          else begin
            e = qb[0];
            chk("b_binary_out", 32'(b_bin), 32'(e.bin));
            chk("b_ch_valid", 32'(b_chv), 32'(e.chv));
            chk("b_ch_err", 32'(b_che), 32'(e.che));
            chk("b_err_count", 32'(b_cnt), 32'(e.cnt));
            if (out_ready) void'(qb.pop_front());
          end
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic clr);
    exp_t ea, eb;
    if (clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end else if (vec_che[k] != 4'b0000) begin
      if (cnt_a < 255) cnt_a++;
      if (cnt_b < 3) cnt_b++;
    end
    ea.bin = vec_hi[k]; ea.chv = vec_chv[k]; ea.che = vec_che[k];
    eb.bin = vec_lo[k]; eb.chv = vec_chv[k]; eb.che = vec_che[k];
`ifdef ONEHOT_ENC_ERR_CNT_EN
    ea.cnt = 8'(cnt_a);
    eb.cnt = 8'(cnt_b);
`else
    ea.cnt = 8'd0;
    eb.cnt = 8'd0;
`endif
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic send(input int k, input logic clr);
    bit done = 1'b0;
    in_valid      = 1'b1;
    one_hot_in    = vec_oh[k];
    err_count_clr = clr;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (a_in_ready && b_in_ready) begin
        push_exp(k, clr);
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    err_count_clr = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, c0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_count_clr = 1'b0; one_hot_in = '0;
    #12;
    chk("rst_out_valid", 32'({a_out_valid, b_out_valid}), 0);
    chk("rst_binary_out", 32'({a_bin, b_bin}), 0);
    chk("rst_ch_flags", 32'({a_chv, a_che, b_chv, b_che}), 0);
    chk("rst_err_count", 32'({a_cnt, b_cnt}), 0);
    chk("rst_in_ready", 32'({a_in_ready, b_in_ready}), 32'b11);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send(k, 1'b0);
    drain();

    p0 = pops_a;
    c0 = cyc;
    send(5, 1'b0); send(0, 1'b0); send(3, 1'b0); send(1, 1'b0);
    chk("stream_input_cycles", 32'(cyc - c0), 4);
    @(negedge clk); #1;
    chk("stream_beats_out", 32'(pops_a - p0), 4);
    drain();

    out_ready = 1'b0;
    send(0, 1'b0);
    in_valid   = 1'b1;
    one_hot_in = vec_oh[3];
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'({a_in_ready, b_in_ready}), 0);
      chk("stall_held_beat", 32'(a_bin), 32'(vec_hi[0]));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(3, 1'b0);
    chk("after_stall_out_valid", 32'(a_out_valid), 1);
    chk("after_stall_binary_out", 32'(b_bin), 32'(vec_lo[3]));
    drain();

    send(0, 1'b1);
    repeat (5) send(1, 1'b0);
    drain();
`ifdef ONEHOT_ENC_ERR_CNT_EN
    chk("sat_b_err_count", 32'(b_cnt), 3);
    chk("sat_a_err_count", 32'(a_cnt), 5);
`else
    chk("sat_b_err_count", 32'(b_cnt), 0);
    chk("sat_a_err_count", 32'(a_cnt), 0);
`endif
    send(2, 1'b1);
    drain();
    chk("clr_err_count", 32'({a_cnt, b_cnt}), 0);

    out_ready = 1'b0;
    send(1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'({a_out_valid, b_out_valid}), 0);
    chk("arst_binary_out", 32'({a_bin, b_bin}), 0);
    chk("arst_err_count", 32'({a_cnt, b_cnt}), 0);
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1 out_ready = 1'b1;
    send(5, 1'b0);
    send(1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
